// File: rtl/logic_op_sequencer_if.sv
// Request/result bundle between the calculator control FSM and the bitwise/shift sequencer.
interface logic_op_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             parity;

    modport master (
        output start, op, x, y,
        input  busy, done, out, zero, parity
    );

    modport slave (
        input  start, op, x, y,
        output busy, done, out, zero, parity
    );
endinterface

// File: rtl/logic_op_sequencer.sv
// Sequences one bitwise op (single cycle) or shift/rotate (one bit per cycle) and
// returns a registered result with zero/parity flags and a one-cycle done pulse.
module logic_op_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logic_op_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   b;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         opr;
    logic [WIDTH-1:0]   logic_res;
    logic [WIDTH-1:0]   shift_res;

    // Single-cycle bitwise function of the latched operands.
    always_comb begin
        logic_res = '0;
        case (opr[1:0])
            2'b00:   logic_res = acc & b;
            2'b01:   logic_res = acc | b;
            2'b10:   logic_res = acc ^ b;
            default: logic_res = ~(acc ^ b);
        endcase
    end

    // One-bit step of the selected shift/rotate.
    always_comb begin
        shift_res = '0;
        case (opr[1:0])
            2'b00:   shift_res = {acc[WIDTH-2:0], 1'b0};
            2'b01:   shift_res = {1'b0, acc[WIDTH-1:1]};
            2'b10:   shift_res = {acc[WIDTH-2:0], acc[WIDTH-1]};
            default: shift_res = {acc[0], acc[WIDTH-1:1]};
        endcase
    end

    assign bus.busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            acc        <= '0;
            b          <= '0;
            cnt        <= '0;
            opr        <= '0;
            bus.out    <= '0;
            bus.zero   <= 1'b0;
            bus.parity <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        acc   <= bus.x;
                        b     <= bus.y;
                        opr   <= bus.op;
                        cnt   <= bus.y[CNT_W-1:0];
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!opr[2]) begin
                        bus.out    <= logic_res;
                        bus.zero   <= (logic_res == '0);
                        bus.parity <= ^logic_res;
                        bus.done   <= 1'b1;
                        state      <= S_DONE;
                    end else if (cnt != '0) begin
                        acc <= shift_res;
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        bus.out    <= acc;
                        bus.zero   <= (acc == '0);
                        bus.parity <= ^acc;
                        bus.done   <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_logic_op_sequencer.sv
// Self-checking bench for logic_op_sequencer: directed test-plan cases plus random ops vs a reference model.
module tb_logic_op_sequencer;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [15:0] last_out;

    logic_op_sequencer_if #(.WIDTH(16)) bus ();

    logic_op_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result from the operation definitions.
    function automatic logic [15:0] ref_result(input logic [2:0] o, input logic [15:0] a, input logic [15:0] c);
        int unsigned n;
        logic [31:0] dbl;
        n = int'(c[3:0]);
        dbl = {a, a};
        case (o)
            3'd0: return a & c;
            3'd1: return a | c;
            3'd2: return a ^ c;
            3'd3: return ~(a ^ c);
            3'd4: return a << n;
            3'd5: return a >> n;
            3'd6: begin dbl = dbl << n; return dbl[31:16]; end
            default: begin dbl = dbl >> n; return dbl[15:0]; end
        endcase
    endfunction

    // Runs one operation; scramble 0 = hold inputs, 1 = zero them, 2 = randomise them after start.
    task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] c, input int scramble);
        logic [15:0] exp;
        int lat;
        int seen;
        exp = ref_result(o, a, c);
        lat = o[2] ? 2 + int'(c[3:0]) : 2;
        @(negedge clk);
        bus.op = o; bus.x = a; bus.y = c; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (scramble == 1) begin bus.x = '0; bus.y = '0; bus.op = 3'd0; end
        if (scramble == 2) begin bus.x = 16'($urandom); bus.y = 16'($urandom); bus.op = 3'($urandom); end
        total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            bad++; $display("FAIL start_busy op=%0d busy=%b done=%b want busy=1 done=0", o, bus.busy, bus.done);
        end
        seen = 0;
        for (int m = 1; m <= 20 && seen == 0; m++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen = m + 1;
            else begin
                total++;
                if (bus.busy !== 1'b1 || bus.out !== last_out) begin
                    bad++; $display("FAIL hold op=%0d busy=%b out=%h want busy=1 out=%h", o, bus.busy, bus.out, last_out);
                end
            end
        end
        total++;
        if (seen != lat) begin
            bad++; $display("FAIL latency op=%0d y=%h got=%0d want=%0d", o, c, seen, lat);
        end
        total++;
        if (bus.out !== exp || bus.zero !== (exp == 16'h0) || bus.parity !== ^exp) begin
            bad++; $display("FAIL result op=%0d x=%h y=%h out=%h z=%b p=%b want out=%h z=%b p=%b",
                            o, a, c, bus.out, bus.zero, bus.parity, exp, exp == 16'h0, ^exp);
        end
        last_out = exp;
        @(posedge clk); #1;
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out !== exp) begin
            bad++; $display("FAIL after_done done=%b busy=%b out=%h want 0 0 %h", bus.done, bus.busy, bus.out, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b0; bus.op = '0; bus.x = '0; bus.y = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 16'h0 || bus.zero !== 1'b0 || bus.parity !== 1'b0) begin
            bad++; $display("FAIL reset busy=%b done=%b out=%h z=%b p=%b want all 0",
                            bus.busy, bus.done, bus.out, bus.zero, bus.parity);
        end
        last_out = 16'h0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_logic();
        run_op(3'd2, 16'hA5A5, 16'h0FF0, 0);
        total++;
        if (bus.out !== 16'hAA55 || bus.zero !== 1'b0 || bus.parity !== 1'b0) begin
            bad++; $display("FAIL xor_const out=%h z=%b p=%b want aa55 0 0", bus.out, bus.zero, bus.parity);
        end
        run_op(3'd0, 16'hF0F0, 16'h0F0F, 0);
        total++;
        if (bus.out !== 16'h0000 || bus.zero !== 1'b1 || bus.parity !== 1'b0) begin
            bad++; $display("FAIL and_zero out=%h z=%b p=%b want 0000 1 0", bus.out, bus.zero, bus.parity);
        end
        run_op(3'd1, 16'h0001, 16'h0000, 0);
        total++;
        if (bus.out !== 16'h0001 || bus.zero !== 1'b0 || bus.parity !== 1'b1) begin
            bad++; $display("FAIL or_par out=%h z=%b p=%b want 0001 0 1", bus.out, bus.zero, bus.parity);
        end
        run_op(3'd3, 16'h1234, 16'h1234, 0);
    endtask

    task automatic test_shift();
        run_op(3'd4, 16'h0001, 16'h0004, 0);
        run_op(3'd6, 16'h8001, 16'h000F, 0);
        total++;
        if (bus.out !== 16'hC000) begin
            bad++; $display("FAIL rol15 out=%h want c000", bus.out);
        end
        run_op(3'd5, 16'h8000, 16'h0000, 0);
        run_op(3'd7, 16'h0001, 16'hFFF1, 0);
    endtask

    task automatic test_stability();
        run_op(3'd5, 16'hFF00, 16'h0003, 1);
        total++;
        if (bus.out !== 16'h1FE0) begin
            bad++; $display("FAIL stability out=%h want 1fe0", bus.out);
        end
    endtask

    task automatic test_start_busy();
        logic [15:0] xr, yr;
        int dones;
        int seen;
        xr = 16'($urandom); yr = 16'($urandom);
        @(negedge clk);
        bus.op = 3'd4; bus.x = 16'h0001; bus.y = 16'h0004; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.op = 3'd2; bus.x = xr; bus.y = yr;
        dones = 0; seen = 0;
        for (int m = 1; m <= 10 && seen == 0; m++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin dones++; seen = m + 1; end
        end
        total++;
        if (dones != 1 || seen != 6 || bus.out !== 16'h0010) begin
            bad++; $display("FAIL busy_ignore dones=%0d cycle=%0d out=%h want 1 6 0010", dones, seen, bus.out);
        end
        @(posedge clk); #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("FAIL done_ignore busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL reaccept busy=%b want 1", bus.busy);
        end
        @(posedge clk); #1;
        total++;
        if (bus.done !== 1'b1 || bus.out !== (xr ^ yr)) begin
            bad++; $display("FAIL reaccept_result done=%b out=%h want 1 %h", bus.done, bus.out, xr ^ yr);
        end
        last_out = xr ^ yr;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int dones;
        @(negedge clk);
        bus.op = 3'd7; bus.x = 16'hBEEF; bus.y = 16'h000F; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 16'h0 || bus.zero !== 1'b0 || bus.parity !== 1'b0) begin
            bad++; $display("FAIL reset_mid busy=%b done=%b out=%h z=%b p=%b want all 0",
                            bus.busy, bus.done, bus.out, bus.zero, bus.parity);
        end
        last_out = 16'h0;
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++; $display("FAIL no_done_after_reset active_cycles=%0d want 0", dones);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_op(3'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_back_to_back();
        run_op(3'd6, 16'h0F0F, 16'h0008, 2);
        run_op(3'd1, 16'h0000, 16'h0000, 0);
        total++;
        if (bus.zero !== 1'b1) begin
            bad++; $display("FAIL b2b_zero z=%b want 1", bus.zero);
        end
        run_op(3'd4, 16'hFFFF, 16'h000F, 0);
    endtask

    initial begin
        total = 0; bad = 0; last_out = 16'h0;
        test_reset();
        test_logic();
        test_shift();
        test_stability();
        test_start_busy();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
